ffram_wb_dma: RTL and testbench

- Wishbone master that sits directly upstream of the FFRAM Wishbone slave and drives its wbs_* port.
- Moves blocks of 32-bit words without CPU involvement, in one of two modes:
  - copy: read word from src, write it to dst.
  - fill: write a constant pattern to dst.
- Started by a single-cycle pulse. Reports busy, done and a sticky error (ack timeout).

---
 rtl/ffram_wb_dma_pkg.sv | 21 ++
 rtl/ffram_wb_dma_if.sv | 23 ++
 rtl/ffram_wb_dma_wb_ack_timer.sv | 28 ++
 rtl/ffram_wb_dma.sv | 132 +++++++++++++
 tb/tb_ffram_wb_dma.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ffram_wb_dma_pkg.sv
// Shared types and constants for the FFRAM Wishbone DMA master.
package ffram_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_GAP,
        WR_REQ,
        WR_GAP,
        FINISH
    } dma_state_t;

    typedef enum logic {
        MODE_COPY,
        MODE_FILL
    } dma_mode_t;

    localparam int unsigned WORD_BYTES = 4;
    localparam logic [3:0]  SEL_ALL    = 4'hF;

endpackage

// File: rtl/ffram_wb_dma_if.sv
// Wishbone master-side bus bundle between the DMA engine and the FFRAM slave.
interface ffram_wb_dma_if;

    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i
    );

endinterface

// File: rtl/ffram_wb_dma_wb_ack_timer.sv
// Counts request cycles without ack; flags expiry on the cycle that would reach TIMEOUT_CYC.
module wb_ack_timer #(
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned TO_W        = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic clear,
    input  logic enable,
    input  logic ack,
    output logic expired
);

    logic [TO_W-1:0] cnt_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            cnt_q <= '0;
        else if (clear)
            cnt_q <= '0;
        else if (enable && !ack)
            cnt_q <= cnt_q + TO_W'(1);
    end

    // An ack in the expiring cycle wins, so expiry is masked by ack.
    assign expired = enable && !ack && (cnt_q == TO_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/ffram_wb_dma.sv
// Wishbone DMA master: block copy or pattern fill into the FFRAM slave, one access at a time.
module ffram_wb_dma
    import ffram_dma_pkg::*;
#(
    parameter int unsigned LEN_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned TO_W        = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               start_i,
    input  logic               mode_i,
    input  logic [31:0]        src_adr_i,
    input  logic [31:0]        dst_adr_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic [31:0]        pattern_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    ffram_wb_dma_if.master     wbm
);

    dma_state_t       state_q, state_d;
    dma_mode_t        mode_q, mode_d;
    logic [31:0]      src_q, src_d, dst_q, dst_d, data_q, data_d, pat_q, pat_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             err_d, busy_d, done_d;
    logic             cyc_q, cyc_d, we_q, we_d;
    logic [3:0]       sel_q, sel_d;
    logic [31:0]      adr_q, adr_d, dat_q, dat_d, req_adr;
    logic             accept, in_req, ack, ack_timeout;

    assign ack    = wbm.wbm_ack_i;
    assign accept = (state_q == IDLE) && start_i;
    assign in_req = (state_q == RD_REQ) || (state_q == WR_REQ);

    wb_ack_timer #(.TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(TO_W)) u_timer (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .clear    (!in_req),
        .enable   (in_req),
        .ack      (ack),
        .expired  (ack_timeout)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (start_i)
                        state_d = (len_i == '0) ? FINISH
                                : (dma_mode_t'(mode_i) == MODE_FILL) ? WR_REQ : RD_REQ;
            RD_REQ: if (ack)              state_d = RD_GAP;
                    else if (ack_timeout) state_d = FINISH;
            RD_GAP: state_d = WR_REQ;
            WR_REQ: if (ack)              state_d = WR_GAP;
                    else if (ack_timeout) state_d = FINISH;
            WR_GAP: state_d = (rem_q == '0) ? FINISH
                            : (mode_q == MODE_FILL) ? WR_REQ : RD_REQ;
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next-state view so the bus follows the state with no lag.
    always_comb begin
        mode_d  = accept ? dma_mode_t'(mode_i) : mode_q;
        pat_d   = accept ? pattern_i : pat_q;
        src_d   = accept ? src_adr_i
                : (state_q == RD_REQ && ack) ? src_q + 32'(WORD_BYTES) : src_q;
        dst_d   = accept ? dst_adr_i
                : (state_q == WR_REQ && ack) ? dst_q + 32'(WORD_BYTES) : dst_q;
        rem_d   = accept ? len_i
                : (state_q == WR_REQ && ack) ? rem_q - LEN_W'(1) : rem_q;
        data_d  = (state_q == RD_REQ && ack) ? wbm.wbm_dat_i : data_q;
        err_d   = accept ? 1'b0 : (ack_timeout ? 1'b1 : err_o);
        busy_d  = (state_d != IDLE);
        done_d  = (state_q == FINISH);
        cyc_d   = (state_d == RD_REQ) || (state_d == WR_REQ);
        we_d    = (state_d == WR_REQ);
        sel_d   = cyc_d ? SEL_ALL : '0;
        req_adr = we_d ? dst_d : src_d;
        adr_d   = cyc_d ? {req_adr[31:2], 2'b00} : '0;
        dat_d   = we_d ? ((mode_d == MODE_FILL) ? pat_d : data_d) : '0;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            mode_q <= MODE_COPY;
            pat_q  <= '0;
            src_q  <= '0;
            dst_q  <= '0;
            rem_q  <= '0;
            data_q <= '0;
            err_o  <= 1'b0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            cyc_q  <= 1'b0;
            we_q   <= 1'b0;
            sel_q  <= '0;
            adr_q  <= '0;
            dat_q  <= '0;
        end else begin
            mode_q <= mode_d;
            pat_q  <= pat_d;
            src_q  <= src_d;
            dst_q  <= dst_d;
            rem_q  <= rem_d;
            data_q <= data_d;
            err_o  <= err_d;
            busy_o <= busy_d;
            done_o <= done_d;
            cyc_q  <= cyc_d;
            we_q   <= we_d;
            sel_q  <= sel_d;
            adr_q  <= adr_d;
            dat_q  <= dat_d;
        end
    end

    assign wbm.wbm_cyc_o = cyc_q;
    assign wbm.wbm_stb_o = cyc_q;
    assign wbm.wbm_we_o  = we_q;
    assign wbm.wbm_sel_o = sel_q;
    assign wbm.wbm_adr_o = adr_q;
    assign wbm.wbm_dat_o = dat_q;

endmodule

// File: tb/tb_ffram_wb_dma.sv
// Bench for ffram_wb_dma with an FFRAM-like slave (ack one cycle after request) and a transfer-level model.
module tb_ffram_wb_dma;

    logic        clk;
    logic        rst;
    logic        start, mode;
    logic [31:0] src, dst, pat;
    logic [7:0]  len;
    logic        busy, done, err;

    ffram_wb_dma_if bus();

    ffram_wb_dma #(.LEN_W(8), .TIMEOUT_CYC(16)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .start_i   (start),
        .mode_i    (mode),
        .src_adr_i (src),
        .dst_adr_i (dst),
        .len_i     (len),
        .pattern_i (pat),
        .busy_o    (busy),
        .done_o    (done),
        .err_o     (err),
        .wbm       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave memory and reference memory, word-addressed by byte address
    logic [31:0] mem [logic [31:0]];
    logic [31:0] mm  [logic [31:0]];
    bit          ack_en = 1'b1;

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] mrd(input logic [31:0] a);
        return mm.exists(a) ? mm[a] : 32'h0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.wbm_ack_i <= 1'b0;
            bus.wbm_dat_i <= 32'h0;
        end else begin
            if (bus.wbm_cyc_o && bus.wbm_stb_o && bus.wbm_ack_i && bus.wbm_we_o)
                mem[bus.wbm_adr_o] = bus.wbm_dat_o;
            bus.wbm_ack_i <= ack_en && bus.wbm_cyc_o && bus.wbm_stb_o && !bus.wbm_ack_i;
            bus.wbm_dat_i <= rd(bus.wbm_adr_o);
        end
    end

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } acc_t;

    acc_t acc_q[$];
    acc_t exp_q[$];
    int   runs_q[$];
    int   run, done_cnt, align_bad, sel_bad;
    bit   busy_prev;

    always @(negedge clk) begin
        if (rst) begin
            run       = 0;
            busy_prev = 1'b0;
        end else begin
            if (bus.wbm_cyc_o && bus.wbm_ack_i)
                acc_q.push_back({bus.wbm_we_o, bus.wbm_adr_o,
                                 bus.wbm_we_o ? bus.wbm_dat_o : bus.wbm_dat_i});
            if (bus.wbm_cyc_o) run++;
            else if (run != 0) begin
                runs_q.push_back(run);
                run = 0;
            end
            if (done) done_cnt++;
            if (done && (busy || !busy_prev)) align_bad++;
            if ((bus.wbm_stb_o !== bus.wbm_cyc_o) ||
                (bus.wbm_sel_o !== (bus.wbm_cyc_o ? 4'hF : 4'h0))) sel_bad++;
            busy_prev = busy;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Transfer-level reference: the list of accesses and the resulting memory image
    task automatic model(input bit m, input logic [31:0] s, input logic [31:0] d,
                         input int n, input logic [31:0] p, input bit ok);
        exp_q.delete();
        mm = mem;
        if (!ok) return;
        for (int i = 0; i < n; i++) begin
            logic [31:0] sa, da, w;
            sa = s + 32'(4 * i);
            da = d + 32'(4 * i);
            if (!m) begin
                w = mrd(sa);
                exp_q.push_back({1'b0, sa, w});
            end else begin
                w = p;
            end
            exp_q.push_back({1'b1, da, w});
            mm[da] = w;
        end
    endtask

    typedef struct {
        bit          mode;
        logic [31:0] src;
        logic [31:0] dst;
        logic [7:0]  len;
        logic [31:0] pat;
        bit          ack_en;
        bit          glitch;
        bit          exp_err;
        int          exp_acc;
    } vec_t;

    task automatic run_xfer(input vec_t v, input string tag);
        int waitc;
        acc_q.delete();
        runs_q.delete();
        done_cnt  = 0;
        align_bad = 0;
        sel_bad   = 0;
        model(v.mode, v.src, v.dst, int'(v.len), v.pat, v.ack_en);
        ack_en = v.ack_en;
        @(negedge clk);
        start = 1'b1; mode = v.mode; src = v.src; dst = v.dst; len = v.len; pat = v.pat;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_err_cleared"}, 32'(err), 32'd0);
        check({tag, "_busy_on"}, 32'(busy), 32'd1);
        if (v.glitch) begin
            repeat (3) @(negedge clk);
            start = 1'b1; src = src + 32'h100; dst = dst + 32'h100; len = 8'd7; mode = ~mode;
            @(negedge clk);
            start = 1'b0;
        end
        waitc = 0;
        while (done_cnt == 0 && waitc < 2000) begin
            @(negedge clk);
            waitc++;
        end
        check({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
        repeat (3) @(negedge clk);
        check({tag, "_done_once"}, 32'(done_cnt), 32'd1);
        check({tag, "_err"}, 32'(err), 32'(v.exp_err));
        check({tag, "_busy_off"}, 32'(busy), 32'd0);
        check({tag, "_done_busy_align"}, 32'(align_bad), 32'd0);
        check({tag, "_sel_stb"}, 32'(sel_bad), 32'd0);
        check({tag, "_acc_count"}, 32'(acc_q.size()), 32'(exp_q.size()));
        check({tag, "_acc_table"}, 32'(acc_q.size()), 32'(v.exp_acc));
        for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_acc%0d_we", tag, i),  32'(acc_q[i].we), 32'(exp_q[i].we));
            check($sformatf("%s_acc%0d_adr", tag, i), acc_q[i].adr, exp_q[i].adr);
            check($sformatf("%s_acc%0d_dat", tag, i), acc_q[i].dat, exp_q[i].dat);
        end
        if (v.ack_en) begin
            for (int i = 0; i < runs_q.size(); i++)
                check($sformatf("%s_cyc_len%0d", tag, i), 32'(runs_q[i]), 32'd2);
        end else begin
            check({tag, "_timeout_runs"}, 32'(runs_q.size()), 32'd1);
            if (runs_q.size() > 0)
                check({tag, "_timeout_cyc_len"}, 32'(runs_q[0]), 32'd16);
        end
        for (int i = 0; i < int'(v.len); i++)
            check($sformatf("%s_mem%0d", tag, i), rd(v.dst + 32'(4 * i)), mrd(v.dst + 32'(4 * i)));
    endtask

    vec_t tbl[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int waitc;
        vec_t rv;

        tbl[0] = '{mode:1'b1, src:32'h0,  dst:32'h10,  len:8'd4, pat:32'hA5A5_5A5A,
                   ack_en:1'b1, glitch:1'b0, exp_err:1'b0, exp_acc:4};
        tbl[1] = '{mode:1'b0, src:32'h0,  dst:32'h40,  len:8'd3, pat:32'h0,
                   ack_en:1'b1, glitch:1'b0, exp_err:1'b0, exp_acc:6};
        tbl[2] = '{mode:1'b1, src:32'h0,  dst:32'h100, len:8'd2, pat:32'h1234_5678,
                   ack_en:1'b0, glitch:1'b0, exp_err:1'b1, exp_acc:0};
        tbl[3] = '{mode:1'b0, src:32'h80, dst:32'hC0,  len:8'd3, pat:32'h0,
                   ack_en:1'b1, glitch:1'b1, exp_err:1'b0, exp_acc:6};
        tbl[4] = '{mode:1'b1, src:32'h0,  dst:32'hFFFF_FFFC, len:8'd2, pat:32'hCAFE_F00D,
                   ack_en:1'b1, glitch:1'b0, exp_err:1'b0, exp_acc:2};

        mem[32'h0]  = 32'h11;
        mem[32'h4]  = 32'h22;
        mem[32'h8]  = 32'h33;
        mem[32'h80] = 32'hAAAA_0001;
        mem[32'h84] = 32'hBBBB_0002;
        mem[32'h88] = 32'hCCCC_0003;
        for (int k = 0; k < 64; k++) mem[32'h400 + 32'(4 * k)] = $urandom;

        rst = 1'b1; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0; pat = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err",  32'(err),  32'd0);
        check("rst_cyc",  32'(bus.wbm_cyc_o), 32'd0);
        check("rst_we",   32'(bus.wbm_we_o),  32'd0);
        check("rst_sel",  32'(bus.wbm_sel_o), 32'd0);
        check("rst_adr",  bus.wbm_adr_o, 32'd0);
        check("rst_dat",  bus.wbm_dat_o, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 5; i++) run_xfer(tbl[i], $sformatf("vec%0d", i));

        // Zero-length start: no bus traffic, busy for one cycle, done the next
        acc_q.delete(); runs_q.delete(); done_cnt = 0;
        @(negedge clk);
        start = 1'b1; len = 8'd0; mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("len0_busy_c1", 32'(busy), 32'd1);
        check("len0_done_c1", 32'(done), 32'd0);
        @(negedge clk);
        check("len0_busy_c2", 32'(busy), 32'd0);
        check("len0_done_c2", 32'(done), 32'd1);
        @(negedge clk);
        check("len0_done_c3", 32'(done), 32'd0);
        check("len0_no_cyc", 32'(runs_q.size() + run), 32'd0);
        check("len0_no_acc", 32'(acc_q.size()), 32'd0);

        // Reset during a write request drops the bus at once and emits no done
        ack_en = 1'b1; done_cnt = 0;
        @(negedge clk);
        start = 1'b1; mode = 1'b1; dst = 32'h300; len = 8'd4; pat = 32'hDEAD_0001;
        @(negedge clk);
        start = 1'b0;
        waitc = 0;
        while (!(bus.wbm_cyc_o && bus.wbm_we_o) && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        check("rst_mid_reached_wr", 32'(bus.wbm_cyc_o && bus.wbm_we_o), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_cyc",  32'(bus.wbm_cyc_o), 32'd0);
        check("rst_mid_stb",  32'(bus.wbm_stb_o), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_mid_no_done", 32'(done_cnt), 32'd0);
        check("rst_mid_idle_bus", 32'(bus.wbm_cyc_o), 32'd0);

        // Randomized transfers against the model
        for (int i = 0; i < 6; i++) begin
            rv.mode    = 1'($urandom_range(0, 1));
            rv.src     = 32'h400 + (32'($urandom_range(0, 56)) << 2);
            rv.dst     = (i == 5) ? 32'hFFFF_FFF8 : 32'h1000 + (32'($urandom_range(0, 200)) << 2);
            rv.len     = 8'($urandom_range(1, 6));
            rv.pat     = $urandom;
            rv.ack_en  = 1'b1;
            rv.glitch  = 1'b0;
            rv.exp_err = 1'b0;
            rv.exp_acc = rv.mode ? int'(rv.len) : 2 * int'(rv.len);
            run_xfer(rv, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
